// File: rtl/mem_port_arbiter.sv
// Two-client arbiter in front of a 1W/2R memory: writes always use port 1.
// Reads take whichever port is free, and read data comes back registered one cycle later.
module mem_port_arbiter #(
  parameter int M = 8,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic         wr0,
  input  logic         wr1,
  input  logic [K-1:0] addr0,
  input  logic [K-1:0] addr1_c,
  input  logic [M-1:0] wdata0,
  input  logic [M-1:0] wdata1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         rvalid0,
  output logic         rvalid1,
  output logic [M-1:0] rdata0,
  output logic [M-1:0] rdata1,
  output logic         mem_we,
  output logic [K-1:0] mem_addr1,
  output logic [K-1:0] mem_addr2,
  output logic [M-1:0] mem_din,
  input  logic [M-1:0] mem_dout1,
  input  logic [M-1:0] mem_dout2
);

  logic         rr_q, rr_d;
  logic         rvalid0_q, rvalid1_q;
  logic [M-1:0] rdata0_q, rdata1_q;
  logic         rd0_d, rd1_d;
  logic         c0_on_p2_d;

  always_comb begin
    gnt0       = 1'b0;
    gnt1       = 1'b0;
    mem_we     = 1'b0;
    mem_addr1  = '0;
    mem_addr2  = '0;
    mem_din    = '0;
    rd0_d      = 1'b0;
    rd1_d      = 1'b0;
    c0_on_p2_d = 1'b0;
    rr_d       = rr_q;

    if (!rst) begin
      if (req0 && req1) begin
        if (wr0 && wr1) begin
          // Only the write port is contended; the loser gets priority next time.
          gnt0 = ~rr_q;
          gnt1 = rr_q;
          rr_d = ~rr_q;
        end else begin
          gnt0 = 1'b1;
          gnt1 = 1'b1;
        end
      end else begin
        gnt0 = req0;
        gnt1 = req1;
      end

      rd0_d = gnt0 & ~wr0;
      rd1_d = gnt1 & ~wr1;

      if (gnt0 && wr0) begin
        mem_we    = 1'b1;
        mem_addr1 = addr0;
        mem_din   = wdata0;
      end
      if (gnt1 && wr1) begin
        mem_we    = 1'b1;
        mem_addr1 = addr1_c;
        mem_din   = wdata1;
      end
      if (rd0_d) begin
        if (gnt1 && wr1) begin
          mem_addr2  = addr0;
          c0_on_p2_d = 1'b1;
        end else begin
          mem_addr1 = addr0;
        end
      end
      // Port 2 is free for c1 in every case: c0 only borrows it when c1 writes.
      if (rd1_d) begin
        mem_addr2 = addr1_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q      <= 1'b0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rr_q      <= rr_d;
      rvalid0_q <= rd0_d;
      rvalid1_q <= rd1_d;
      if (rd0_d) begin
        rdata0_q <= c0_on_p2_d ? mem_dout2 : mem_dout1;
      end
      if (rd1_d) begin
        rdata1_q <= mem_dout2;
      end
    end
  end

  // A response pending when reset arrives is suppressed immediately.
  assign rvalid0 = rvalid0_q & ~rst;
  assign rvalid1 = rvalid1_q & ~rst;
  assign rdata0  = rst ? '0 : rdata0_q;
  assign rdata1  = rst ? '0 : rdata1_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural async-read/sync-write memory.
// Expected values are hand-computed constants.
module tb_mem_port_arbiter;
  localparam int M = 8;
  localparam int K = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         req0, req1, wr0, wr1;
  logic [K-1:0] addr0, addr1_c;
  logic [M-1:0] wdata0, wdata1;
  logic         gnt0, gnt1, rvalid0, rvalid1;
  logic [M-1:0] rdata0, rdata1;
  logic         mem_we;
  logic [K-1:0] mem_addr1, mem_addr2;
  logic [M-1:0] mem_din, mem_dout1, mem_dout2;

  logic [M-1:0] mem [16];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.M(M), .K(K)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1_c(addr1_c), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_we(mem_we), .mem_addr1(mem_addr1), .mem_addr2(mem_addr2),
    .mem_din(mem_din), .mem_dout1(mem_dout1), .mem_dout2(mem_dout2)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr1] <= mem_din;
  end
  assign mem_dout1 = mem[mem_addr1];
  assign mem_dout2 = mem[mem_addr2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic c0(input logic rq, input logic w, input logic [K-1:0] a, input logic [M-1:0] d);
    req0 = rq; wr0 = w; addr0 = a; wdata0 = d;
  endtask

  task automatic c1(input logic rq, input logic w, input logic [K-1:0] a, input logic [M-1:0] d);
    req1 = rq; wr1 = w; addr1_c = a; wdata1 = d;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    rst = 1'b1;
    c0(1'b1, 1'b1, 4'd1, 8'h01);
    c1(1'b1, 1'b1, 4'd2, 8'h02);
    #1;
    // 1: reset overrides grants and write enable
    chk("rst_gnt0", 32'(gnt0), 0);
    chk("rst_gnt1", 32'(gnt1), 0);
    chk("rst_we", 32'(mem_we), 0);
    tick();
    tick();
    chk("rst_rvalid0", 32'(rvalid0), 0);
    chk("rst_rvalid1", 32'(rvalid1), 0);
    chk("rst_rdata0", 32'(rdata0), 0);
    $display("txn reset: gnt0=%0b gnt1=%0b we=%0b", gnt0, gnt1, mem_we);
    rst = 1'b0;
    c0(1'b0, 1'b0, 4'd0, 8'h00);
    c1(1'b0, 1'b0, 4'd0, 8'h00);
    #1;
    chk("idle_addr1", 32'(mem_addr1), 0);

    // 2: c0 write then read addr 7
    c0(1'b1, 1'b1, 4'd7, 8'd127);
    #1;
    chk("t2_wr_gnt0", 32'(gnt0), 1);
    chk("t2_wr_we", 32'(mem_we), 1);
    chk("t2_wr_addr1", 32'(mem_addr1), 7);
    chk("t2_wr_din", 32'(mem_din), 127);
    $display("txn c0 write a=7 d=127 gnt0=%0b", gnt0);
    tick();
    c0(1'b1, 1'b0, 4'd7, 8'h00);
    #1;
    chk("t2_rd_gnt0", 32'(gnt0), 1);
    chk("t2_rd_we", 32'(mem_we), 0);
    tick();
    c0(1'b0, 1'b0, 4'd0, 8'h00);
    chk("t2_rvalid0", 32'(rvalid0), 1);
    chk("t2_rdata0", 32'(rdata0), 127);
    $display("txn c0 read a=7 rvalid0=%0b rdata0=%0h", rvalid0, rdata0);
    tick();
    chk("t2_rvalid0_pulse", 32'(rvalid0), 0);

    // 3: contested writes to addr 8, both held for two cycles
    c0(1'b1, 1'b1, 4'd8, 8'hAA);
    c1(1'b1, 1'b1, 4'd8, 8'h55);
    #1;
    chk("t3_c1_gnt0", 32'(gnt0), 1);
    chk("t3_c1_gnt1", 32'(gnt1), 0);
    chk("t3_c1_din", 32'(mem_din), 32'hAA);
    tick();
    #1;
    chk("t3_c2_gnt0", 32'(gnt0), 0);
    chk("t3_c2_gnt1", 32'(gnt1), 1);
    chk("t3_c2_din", 32'(mem_din), 32'h55);
    chk("t3_c2_addr1", 32'(mem_addr1), 8);
    $display("txn contested write a=8 winner c1 din=%0h", mem_din);
    tick();
    c1(1'b0, 1'b0, 4'd0, 8'h00);
    c0(1'b1, 1'b0, 4'd8, 8'h00);
    tick();
    c0(1'b0, 1'b0, 4'd0, 8'h00);
    chk("t3_rdata0", 32'(rdata0), 32'h55);
    // pointer should be back at c0
    c0(1'b1, 1'b1, 4'd9, 8'h01);
    c1(1'b1, 1'b1, 4'd9, 8'h02);
    #1;
    chk("t3_rr_gnt0", 32'(gnt0), 1);
    chk("t3_rr_gnt1", 32'(gnt1), 0);
    $display("txn contested write a=9 gnt0=%0b gnt1=%0b", gnt0, gnt1);
    tick();
    c0(1'b0, 1'b0, 4'd0, 8'h00);
    c1(1'b0, 1'b0, 4'd0, 8'h00);

    // 4: c0 write + c1 read same address returns old data
    c0(1'b1, 1'b1, 4'd3, 8'h11);
    c1(1'b1, 1'b0, 4'd3, 8'h00);
    #1;
    chk("t4_gnt0", 32'(gnt0), 1);
    chk("t4_gnt1", 32'(gnt1), 1);
    chk("t4_addr2", 32'(mem_addr2), 3);
    tick();
    c0(1'b0, 1'b0, 4'd0, 8'h00);
    chk("t4_rvalid1", 32'(rvalid1), 1);
    chk("t4_rdata1_old", 32'(rdata1), 0);
    #1;
    chk("t4_rr_addr2", 32'(mem_addr2), 3);
    tick();
    c1(1'b0, 1'b0, 4'd0, 8'h00);
    chk("t4_rdata1_new", 32'(rdata1), 32'h11);
    $display("txn c1 re-read a=3 rdata1=%0h", rdata1);

    // 4b: c1 write + c0 read: c0 moves to port 2
    c0(1'b1, 1'b0, 4'd5, 8'h00);
    c1(1'b1, 1'b1, 4'd5, 8'h66);
    #1;
    chk("t4b_addr1", 32'(mem_addr1), 5);
    chk("t4b_addr2", 32'(mem_addr2), 5);
    chk("t4b_din", 32'(mem_din), 32'h66);
    tick();
    c0(1'b0, 1'b0, 4'd0, 8'h00);
    c1(1'b0, 1'b0, 4'd0, 8'h00);
    chk("t4b_rdata0_old", 32'(rdata0), 0);
    $display("txn c0 read a=5 during c1 write rdata0=%0h", rdata0);

    // 5: read + read
    c0(1'b1, 1'b0, 4'd7, 8'h00);
    c1(1'b1, 1'b0, 4'd8, 8'h00);
    #1;
    chk("t5_gnt0", 32'(gnt0), 1);
    chk("t5_gnt1", 32'(gnt1), 1);
    chk("t5_addr1", 32'(mem_addr1), 7);
    chk("t5_addr2", 32'(mem_addr2), 8);
    tick();
    c0(1'b0, 1'b0, 4'd0, 8'h00);
    c1(1'b0, 1'b0, 4'd0, 8'h00);
    chk("t5_rvalid0", 32'(rvalid0), 1);
    chk("t5_rvalid1", 32'(rvalid1), 1);
    chk("t5_rdata0", 32'(rdata0), 127);
    chk("t5_rdata1", 32'(rdata1), 32'h55);
    $display("txn dual read rdata0=%0h rdata1=%0h", rdata0, rdata1);
    tick();

    // 6: reset the cycle after a read grant
    c0(1'b1, 1'b0, 4'd7, 8'h00);
    #1;
    chk("t6_gnt0", 32'(gnt0), 1);
    tick();
    c0(1'b0, 1'b0, 4'd0, 8'h00);
    rst = 1'b1;
    #1;
    chk("t6_rvalid0_rst", 32'(rvalid0), 0);
    tick();
    chk("t6_rvalid0", 32'(rvalid0), 0);
    chk("t6_rdata0", 32'(rdata0), 0);
    rst = 1'b0;
    tick();
    chk("t6_rdata0_after", 32'(rdata0), 0);
    $display("txn read then reset rvalid0=%0b rdata0=%0h", rvalid0, rdata0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
